// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the RV32I fetch stage.
// Predicts the next fetch PC, carries the prediction to EX, trains from EX and counts mispredicts.
module btb_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        flush_d_i,
  input  logic        flush_e_i,
  input  logic [31:0] pc_f_i,
  output logic        predict_o,
  output logic [31:0] pc_next_o,
  output logic        pred_e_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        mispredict_i,
  output logic [31:0] mispred_cnt_o
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]      valid_reg;
  logic [ENTRIES-1:0]      valid_next;
  logic [ENTRIES-1:0][1:0] ctr_reg;
  logic [ENTRIES-1:0][1:0] ctr_next;
  logic [ENTRIES-1:0]      upd_sel;

  // Tag and target contents are only meaningful where valid is set, so they carry no reset.
  logic [TAG_W-1:0] tag_mem    [ENTRIES];
  logic [31:0]      target_mem [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_u;
  logic [TAG_W-1:0] tag_u;
  logic             hit_f;
  logic             hit_u;
  logic [1:0]       ctr_u_next;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_pc;

  logic        pred_d_reg;
  logic        pred_d_next;
  logic        pred_e_reg;
  logic        pred_e_next;
  logic [31:0] mispred_cnt_reg;
  logic [31:0] mispred_cnt_next;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken) begin
      if (ctr != 2'b11) result = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) result = ctr - 2'b01;
    end
    return result;
  endfunction

  assign idx_f = pc_f_i[IDX_W+1:2];
  assign tag_f = pc_f_i[31:IDX_W+2];
  assign idx_u = upd_pc_i[IDX_W+1:2];
  assign tag_u = upd_pc_i[31:IDX_W+2];

  assign hit_f = valid_reg[idx_f] && (tag_mem[idx_f] == tag_f);
  assign hit_u = valid_reg[idx_u] && (tag_mem[idx_u] == tag_u);

  assign ctr_u_next = ctr_train(ctr_reg[idx_u], upd_taken_i);

  // Lookup: reset masks the prediction but the mispredict redirect still passes through.
  assign predict_o   = rst_n && hit_f && ctr_reg[idx_f][1];
  assign pc_plus4    = pc_f_i + 32'd4;
  assign redirect_pc = upd_taken_i ? upd_target_i : (upd_pc_i + 32'd4);

  always_comb begin
    pc_next_o = pc_plus4;
    if (mispredict_i) begin
      pc_next_o = redirect_pc;
    end else if (predict_o) begin
      pc_next_o = target_mem[idx_f];
    end
  end

  // Per-entry training: hits move the counter, taken misses allocate weakly taken.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign upd_sel[gi]    = upd_valid_i && (idx_u == IDX_W'(gi));
      assign valid_next[gi] = (upd_sel[gi] && !hit_u && upd_taken_i) ? 1'b1 : valid_reg[gi];
      assign ctr_next[gi]   = !upd_sel[gi] ? ctr_reg[gi] :
                              hit_u        ? ctr_u_next  :
                              upd_taken_i  ? 2'b10       : ctr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid_reg <= '0;
      ctr_reg   <= {ENTRIES{2'b01}};
    end else begin
      valid_reg <= valid_next;
      ctr_reg   <= ctr_next;
    end
  end

  // A taken update rewrites tag and target on both hit and allocate; tag is unchanged on a hit.
  always_ff @(posedge clk_i) begin
    if (rst_n && upd_valid_i && upd_taken_i) begin
      tag_mem[idx_u]    <= tag_u;
      target_mem[idx_u] <= upd_target_i;
    end
  end

  always_comb begin
    pred_d_next = pred_d_reg;
    if (flush_d_i) begin
      pred_d_next = 1'b0;
    end else if (en_i) begin
      pred_d_next = predict_o;
    end
    pred_e_next = flush_e_i ? 1'b0 : pred_d_reg;
    mispred_cnt_next = mispred_cnt_reg;
    if (mispredict_i && (mispred_cnt_reg != 32'hFFFF_FFFF)) begin
      mispred_cnt_next = mispred_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pred_d_reg      <= 1'b0;
      pred_e_reg      <= 1'b0;
      mispred_cnt_reg <= 32'd0;
    end else begin
      pred_d_reg      <= pred_d_next;
      pred_e_reg      <= pred_e_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign pred_e_o      = pred_e_reg;
  assign mispred_cnt_o = mispred_cnt_reg;

endmodule
